// File: rtl/spi_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one SPI master, one word per grant.
// state | meaning: IDLE wait for req | ISSUE new_data strobe | WAIT await spi_done rise | DONE ack/err, release
module spi_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 12,
  parameter int HOLD    = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic                err,
  output logic                busy,
  output logic                new_data,
  output logic [DW-1:0]       din,
  input  logic                spi_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_TC   = CW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             nd_q, nd_d;
  logic [DW-1:0]    din_q, din_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             sdly_q, sdly_d;

  logic             rr_found;
  logic [IW-1:0]    rr_idx;
  logic [IW-1:0]    rr_probe;
  logic [N_REQ-1:0] rr_onehot;
  logic [DW-1:0]    rr_word;
  logic             sd_rise;
  logic             tout;

  // Search starts just after the last winner and wraps, so a re-asserted req queues behind the others.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_probe = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_probe = IW'((int'(last_q) + k) % N_REQ);
      if (!rr_found && req[rr_probe]) begin
        rr_found = 1'b1;
        rr_idx   = rr_probe;
      end
    end
  end

  always_comb begin
    rr_word   = '0;
    rr_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_idx == IW'(i)) begin
        rr_word      = req_data[i*DW +: DW];
        rr_onehot[i] = 1'b1;
      end
    end
  end

  assign sd_rise = spi_done & ~sdly_q;
  assign tout    = (cnt_q == CNT_TC);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    nd_d    = nd_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    sdly_d  = spi_done;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          win_d   = rr_idx;
          gnt_d   = rr_onehot;
          din_d   = rr_word;
          busy_d  = 1'b1;
          nd_d    = 1'b1;
          cnt_d   = '0;
          hold_d  = HOLD_LD;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (sd_rise) begin
          nd_d    = 1'b0;
          ack_d   = gnt_q;
          state_d = DONE;
        end else if (tout) begin
          nd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (hold_q == '0) begin
          nd_d    = 1'b0;
          state_d = WAIT;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end

      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (sd_rise) begin
          ack_d   = gnt_q;
          state_d = DONE;
        end else if (tout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        last_d  = win_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        din_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        nd_d    = 1'b0;
        din_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      nd_q    <= 1'b0;
      din_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      sdly_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      nd_q    <= nd_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      sdly_q  <= sdly_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign new_data = nd_q;
  assign din      = din_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: stimulus queues expected completions, a monitor checks each ack/err.
module tb_spi_arbiter;
  localparam int N_REQ   = 4;
  localparam int DW      = 12;
  localparam int HOLD    = 12;
  localparam int TIMEOUT = 255;
  localparam logic [N_REQ*DW-1:0] WORDS = {12'h789, 12'h456, 12'h123, 12'hA5C};

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*DW-1:0] req_data = '0;
  logic                spi_done = 1'b0;
  logic [N_REQ-1:0]    gnt, ack;
  logic                err, busy, new_data;
  logic [DW-1:0]       din;

  spi_arbiter #(.N_REQ(N_REQ), .DW(DW), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .ack(ack), .err(err), .busy(busy), .new_data(new_data),
    .din(din), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gnt;
    logic [11:0] din;
    logic        is_err;
    int          lat;
    int          nd;
  } exp_t;

  exp_t sb_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Latency counts cycles from the first busy cycle; new_data length counts strobe cycles.
  task automatic monitor();
    logic busy_prev = 1'b0;
    int lat = 0;
    int nd = 0;
    logic stable = 1'b1;
    logic [3:0] sg = '0;
    logic [11:0] sd = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && !busy_prev) begin
        lat = 0; nd = 0; stable = 1'b1; sg = gnt; sd = din;
      end else if (busy) begin
        lat++;
        if (gnt !== sg || din !== sd) stable = 1'b0;
      end
      if (busy && new_data) nd++;
      if (|ack || err) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", {27'b0, ack, err}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          chk("gnt", {28'b0, gnt}, {28'b0, e.gnt});
          chk("din", {20'b0, din}, {20'b0, e.din});
          chk("ack", {28'b0, ack}, {28'b0, (e.is_err ? 4'b0 : e.gnt)});
          chk("err", {31'b0, err}, {31'b0, e.is_err});
          chk("latency", lat, e.lat);
          chk("new_data_len", nd, e.nd);
          chk("gnt_din_stable", {31'b0, stable}, 32'h1);
        end
      end
      busy_prev = busy;
    end
  endtask

  task automatic run_txn(input logic [3:0] eg, input logic [11:0] ed, input int d,
                         input logic abort, input logic pre_high, input logic [3:0] req_after);
    exp_t e;
    int n;
    e.gnt    = eg;
    e.din    = ed;
    e.is_err = abort;
    e.lat    = abort ? TIMEOUT : d + 1;
    e.nd     = abort ? HOLD : ((d + 1 < HOLD) ? d + 1 : HOLD);
    sb_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      chk("grant_seen", {31'b0, busy}, 32'h1);
      return;
    end
    req      = req_after;
    req_data = ~WORDS;
    if (!abort) begin
      if (pre_high) begin
        repeat (10) @(posedge clk);
        #1 spi_done = 1'b0;
        repeat (d - 10) @(posedge clk);
      end else begin
        repeat (d) @(posedge clk);
      end
      #1 spi_done = 1'b1;
      @(posedge clk);
      #1 spi_done = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("busy_clear", {31'b0, busy}, 32'h0);
    req_data = WORDS;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, {28'b0, gnt}, 32'h0);
    chk({tag, "_ack"}, {28'b0, ack}, 32'h0);
    chk({tag, "_err"}, {31'b0, err}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_new_data"}, {31'b0, new_data}, 32'h0);
    chk({tag, "_din"}, {20'b0, din}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic stimulus();
    int n;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk) reset = 1'b1;

    // all four requesting after reset: order 0,1,2,3; first one completes inside ISSUE
    @(negedge clk) req = 4'b1111;
    run_txn(4'b0001, 12'hA5C, 5,  1'b0, 1'b0, 4'b1111);
    run_txn(4'b0010, 12'h123, 20, 1'b0, 1'b0, 4'b1111);
    run_txn(4'b0100, 12'h456, 3,  1'b0, 1'b0, 4'b1111);
    run_txn(4'b1000, 12'h789, 15, 1'b0, 1'b0, 4'b0000);

    // single request, spi_done 40 cycles later
    req = 4'b0001;
    run_txn(4'b0001, 12'hA5C, 40, 1'b0, 1'b0, 4'b0000);

    // req0 held with req2: 0,2,0,2; one completion coincides with the end of the strobe
    do_reset();
    req = 4'b0101;
    run_txn(4'b0001, 12'hA5C, 2,  1'b0, 1'b0, 4'b0101);
    run_txn(4'b0100, 12'h456, 11, 1'b0, 1'b0, 4'b0101);
    run_txn(4'b0001, 12'hA5C, 30, 1'b0, 1'b0, 4'b0101);
    run_txn(4'b0100, 12'h456, 6,  1'b0, 1'b0, 4'b0000);

    // timeout abort on requester 3, then requester 1 is next
    req = 4'b1010;
    run_txn(4'b1000, 12'h789, 0, 1'b1, 1'b0, 4'b1010);
    run_txn(4'b0010, 12'h123, 7, 1'b0, 1'b0, 4'b0000);

    // spi_done already high at grant; then an edge coincident with the timeout
    spi_done = 1'b1;
    req = 4'b0100;
    run_txn(4'b0100, 12'h456, 20, 1'b0, 1'b1, 4'b0000);
    req = 4'b1000;
    run_txn(4'b1000, 12'h789, TIMEOUT - 1, 1'b0, 1'b0, 4'b0000);

    // reset during WAIT, then a fresh search from requester 0 wraps to 3
    req = 4'b0010;
    n = 0;
    @(negedge clk);
    while (!busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_grant", {28'b0, gnt}, 32'h2);
    req = 4'b0000;
    repeat (30) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_idle_outputs("midrst");
    req = 4'b1000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_txn(4'b1000, 12'h789, 9, 1'b0, 1'b0, 4'b0000);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'h0);
  endtask

  initial begin
    req_data = WORDS;
    fork
      monitor();
      stimulus();
    join_any
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
